// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// trace_capture_buffer: filters multi-lane retire events into a record FIFO
// Rev 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 filter_mode,
  input  logic                       clear,
  input  logic [2:0]                 priv_mode,
  input  logic [XLEN-1:0]            timer,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_excpt,
  input  logic [LANES-1:0]           in_wrenx,
  input  logic [LANES-1:0]           in_wrenf,
  input  logic [LANES*XLEN-1:0]      in_pc,
  input  logic [LANES*XLEN-1:0]      in_inst,
  input  logic [LANES*XLEN-1:0]      in_wrdata,
  input  logic [LANES*5-1:0]         in_wrdst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_wrdata,
  output logic [XLEN-1:0]            out_timer,
  output logic [4:0]                 out_wrdst,
  output logic                       out_wrenx,
  output logic                       out_wrenf,
  output logic                       out_excpt,
  output logic                       out_gap,
  output logic [2:0]                 out_priv,
  output logic                       out_lane,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 4 * XLEN + 13;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             gap_pending;
  logic             pop;
  logic [LANES-1:0] qual;
  logic [LANES-1:0] wr_en;
  logic [AW-1:0]    wr_addr [LANES];
  logic [RW-1:0]    wr_rec  [LANES];
  logic [CW-1:0]    free_slots, n_store;
  logic [1:0]       n_drop;
  logic             gap_run;
  logic [16:0]      drop_sum;
  logic [RW-1:0]    rd_rec;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    qual = '0;
    for (int i = 0; i < LANES; i++) begin
      case (filter_mode)
        2'b00:   qual[i] = 1'b1;
        2'b01:   qual[i] = in_excpt[i];
        2'b10:   qual[i] = in_wrenx[i] | in_wrenf[i];
        default: qual[i] = in_excpt[i] | in_wrenx[i] | in_wrenf[i];
      endcase
      qual[i] = qual[i] & enable & in_valid[i];
    end
  end

  // Lanes are allocated in ascending order; once slots run out every later
  // qualifying lane is a drop and re-arms the gap flag for the next store.
  always_comb begin
    free_slots = CW'(DEPTH) - count + CW'(pop);
    n_store    = '0;
    n_drop     = '0;
    gap_run    = gap_pending & ~clear;
    wr_en      = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_addr[i] = wr_ptr + n_store[AW-1:0];
      wr_rec[i]  = {1'(i), priv_mode, gap_run, in_excpt[i], in_wrenf[i],
                    in_wrenx[i], in_wrdst[i*5 +: 5], timer,
                    in_wrdata[i*XLEN +: XLEN], in_inst[i*XLEN +: XLEN],
                    in_pc[i*XLEN +: XLEN]};
      if (qual[i]) begin
        if (n_store < free_slots) begin
          wr_en[i] = 1'b1;
          n_store  = n_store + 1'b1;
          gap_run  = 1'b0;
        end else begin
          n_drop  = n_drop + 1'b1;
          gap_run = 1'b1;
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap_pending <= 1'b0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + n_store[AW-1:0];
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count + n_store - CW'(pop);
      gap_pending <= gap_run;
      if (clear) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end else begin
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (n_drop != '0) overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: an empty FIFO masks every output field.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_rec[i];
    end
  end

  assign rd_rec = out_valid ? mem[rd_ptr] : '0;

  assign out_pc     = rd_rec[0*XLEN +: XLEN];
  assign out_inst   = rd_rec[1*XLEN +: XLEN];
  assign out_wrdata = rd_rec[2*XLEN +: XLEN];
  assign out_timer  = rd_rec[3*XLEN +: XLEN];
  assign out_wrdst  = rd_rec[4*XLEN +: 5];
  assign out_wrenx  = rd_rec[4*XLEN + 5];
  assign out_wrenf  = rd_rec[4*XLEN + 6];
  assign out_excpt  = rd_rec[4*XLEN + 7];
  assign out_gap    = rd_rec[4*XLEN + 8];
  assign out_priv   = rd_rec[4*XLEN + 9 +: 3];
  assign out_lane   = rd_rec[4*XLEN + 12];

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// tb_trace_capture_buffer: queue-model scoreboard bench for trace_capture_buffer
// Rev 1.0 - initial release
// ============================================================================
module tb_trace_capture_buffer;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  filter_mode = 2'b00;
  logic [2:0]  priv_mode = 3'd3;
  logic [31:0] timer = 32'h0000_1000;
  logic [1:0]  in_valid = '0, in_excpt = '0, in_wrenx = '0, in_wrenf = '0;
  logic [63:0] in_pc = '0, in_inst = '0, in_wrdata = '0;
  logic [9:0]  in_wrdst = '0;

  logic        out_valid, out_wrenx, out_wrenf, out_excpt, out_gap, out_lane, overflow;
  logic [31:0] out_pc, out_inst, out_wrdata, out_timer;
  logic [4:0]  out_wrdst;
  logic [2:0]  out_priv;
  logic [2:0]  count;
  logic [15:0] drop_count;

  trace_capture_buffer #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .enable(enable), .filter_mode(filter_mode),
    .clear(clear), .priv_mode(priv_mode), .timer(timer),
    .in_valid(in_valid), .in_excpt(in_excpt), .in_wrenx(in_wrenx), .in_wrenf(in_wrenf),
    .in_pc(in_pc), .in_inst(in_inst), .in_wrdata(in_wrdata), .in_wrdst(in_wrdst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wrdata(out_wrdata), .out_timer(out_timer),
    .out_wrdst(out_wrdst), .out_wrenx(out_wrenx), .out_wrenf(out_wrenf),
    .out_excpt(out_excpt), .out_gap(out_gap), .out_priv(out_priv), .out_lane(out_lane),
    .count(count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, inst, wrdata, timer;
    logic [4:0]  wrdst;
    logic        wrenx, wrenf, excpt, gap, lane;
    logic [2:0]  priv;
  } rec_t;

  typedef struct {
    logic       en;
    logic [1:0] mode, valid, ex, wx, wf;
    int         exp_n;
    logic       exp_lane;
  } vec_t;

  rec_t        mq[$];
  vec_t        vt[9];
  int          checks = 0, errors = 0;
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0, m_gap = 1'b0;
  bit          quiet = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_qual(input int i);
    bit wb;
    wb = in_wrenx[i] | in_wrenf[i];
    if (!enable || !in_valid[i]) return 1'b0;
    if (filter_mode == 2'b00) return 1'b1;
    if (filter_mode == 2'b01) return in_excpt[i];
    if (filter_mode == 2'b10) return wb;
    return in_excpt[i] | wb;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] pc, input logic ex,
                          input logic wx, input logic wf);
    in_valid[i]           = 1'b1;
    in_excpt[i]           = ex;
    in_wrenx[i]           = wx;
    in_wrenf[i]           = wf;
    in_pc[i*32 +: 32]     = pc;
    in_inst[i*32 +: 32]   = pc ^ 32'hA5A5_0000;
    in_wrdata[i*32 +: 32] = pc + 32'd7;
    in_wrdst[i*5 +: 5]    = pc[6:2];
  endtask

  task automatic idle();
    in_valid = '0; in_excpt = '0; in_wrenx = '0; in_wrenf = '0;
  endtask

  // Compare at the falling edge, then advance the model across the next rising edge.
  task automatic step();
    rec_t r;
    bit   g;
    int   nd, t;
    if (!quiet) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (mq.size() != 0) begin
        chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
        chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
        chk("out_wrdata", 64'(out_wrdata), 64'(mq[0].wrdata));
        chk("out_timer", 64'(out_timer), 64'(mq[0].timer));
        chk("out_ctl", 64'({out_wrdst, out_wrenx, out_wrenf, out_excpt, out_priv}),
            64'({mq[0].wrdst, mq[0].wrenx, mq[0].wrenf, mq[0].excpt, mq[0].priv}));
        chk("out_gap", 64'(out_gap), 64'(mq[0].gap));
        chk("out_lane", 64'(out_lane), 64'(mq[0].lane));
      end else begin
        chk("idle_pc", 64'(out_pc | out_inst | out_wrdata), 64'd0);
        chk("idle_misc", 64'({out_timer, out_priv, out_gap, out_lane, out_excpt,
                              out_wrenx, out_wrenf, out_wrdst}), 64'd0);
      end
    end
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    g  = m_gap & ~clear;
    nd = 0;
    for (int i = 0; i < LANES; i++) begin
      if (m_qual(i)) begin
        if (mq.size() < DEPTH) begin
          r.pc = in_pc[i*32 +: 32];         r.inst = in_inst[i*32 +: 32];
          r.wrdata = in_wrdata[i*32 +: 32]; r.timer = timer;
          r.wrdst = in_wrdst[i*5 +: 5];     r.wrenx = in_wrenx[i];
          r.wrenf = in_wrenf[i];            r.excpt = in_excpt[i];
          r.priv = priv_mode;               r.lane = 1'(i);
          r.gap = g;
          mq.push_back(r);
          g = 1'b0;
        end else begin
          nd++;
          g = 1'b1;
        end
      end
    end
    m_gap = g;
    if (clear) begin
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      if (nd > 0) m_ovf = 1'b1;
      t = int'(m_drop) + nd;
      m_drop = (t > 65535) ? 16'hFFFF : 16'(t);
    end
    @(posedge clock);
    @(negedge clock);
    timer     = timer + 32'h11;
    priv_mode = priv_mode + 3'd1;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 12 && mq.size() != 0; k++) step();
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en    mode   valid  ex     wx     wf     n  lane
    vt[0] = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2, 1'b0};
    vt[1] = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1'b1};
    vt[2] = '{1'b1, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 1, 1'b1};
    vt[3] = '{1'b1, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 0, 1'b0};
    vt[4] = '{1'b1, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 1, 1'b0};
    vt[5] = '{1'b1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10, 1, 1'b1};
    vt[6] = '{1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2, 1'b0};
    vt[7] = '{1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0};
    vt[8] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1'b0};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock);

    // Dual-lane push with immediate drain: 0x100 lane0 then 0x104 lane1
    out_ready = 1'b1;
    set_lane(0, 32'h100, 1'b0, 1'b1, 1'b0);
    set_lane(1, 32'h104, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    chk("dual_count2", 64'(count), 64'd2);
    chk("dual_first_pc", 64'(out_pc), 64'h100);
    step();
    chk("dual_count1", 64'(count), 64'd1);
    chk("dual_second_pc", 64'(out_pc), 64'h104);
    step();
    chk("dual_count0", 64'(count), 64'd0);

    // Filter / enable vectors
    for (int v = 0; v < 9; v++) begin
      drain();
      out_ready   = 1'b0;
      enable      = vt[v].en;
      filter_mode = vt[v].mode;
      for (int i = 0; i < LANES; i++) begin
        set_lane(i, 32'h2FC + 32'(4 * i), vt[v].ex[i], vt[v].wx[i], vt[v].wf[i]);
        in_valid[i] = vt[v].valid[i];
      end
      step();
      idle();
      chk("vec_count", 64'(count), 64'(vt[v].exp_n));
      if (vt[v].exp_n > 0) chk("vec_lane", 64'(out_lane), 64'(vt[v].exp_lane));
      step();
      enable = 1'b1;
    end
    filter_mode = 2'b00;

    // Overflow into a 4-deep FIFO, then gap marking
    drain();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 32'h10 + 32'(8 * c), 1'b0, 1'b0, 1'b0);
      set_lane(1, 32'h14 + 32'(8 * c), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    set_lane(0, 32'h30, 1'b0, 1'b0, 1'b0);
    set_lane(1, 32'h34, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("full_pop_count", 64'(count), 64'd4);
    chk("full_pop_drop", 64'(drop_count), 64'd3);
    drain();
    out_ready = 1'b0;
    set_lane(0, 32'h200, 1'b0, 1'b0, 1'b0);
    step();
    set_lane(0, 32'h204, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("gap_first_pc", 64'(out_pc), 64'h200);
    chk("gap_first", 64'(out_gap), 64'd1);
    out_ready = 1'b1;
    step();
    chk("gap_second", 64'(out_gap), 64'd0);

    // Hold stability, drop saturation, clear coincident with drops
    drain();
    out_ready = 1'b0;
    set_lane(0, 32'h400, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    repeat (5) step();
    chk("hold_pc", 64'(out_pc), 64'h400);
    set_lane(0, 32'h410, 1'b0, 1'b0, 1'b0);
    set_lane(1, 32'h414, 1'b0, 1'b0, 1'b0);
    quiet = 1'b1;
    for (int k = 0; k < 40000 && m_drop != 16'hFFFF; k++) step();
    repeat (3) step();
    quiet = 1'b0;
    step();
    chk("drop_sat", 64'(drop_count), 64'hFFFF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle();
    chk("clear_drop", 64'(drop_count), 64'd0);
    chk("clear_ovf", 64'(overflow), 64'd0);
    drain();
    out_ready = 1'b0;
    set_lane(0, 32'h420, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("clear_gap_kept", 64'(out_gap), 64'd1);

    // Reset during an active drain with a gap pending
    drain();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 32'h500 + 32'(8 * c), 1'b0, 1'b0, 1'b0);
      set_lane(1, 32'h504 + 32'(8 * c), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
    set_lane(0, 32'h510, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    out_ready = 1'b1;
    step();
    chk("pre_rst_count", 64'(count), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_pc", 64'(out_pc), 64'd0);
    mq.delete();
    m_drop = '0;
    m_ovf  = 1'b0;
    m_gap  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    set_lane(0, 32'h600, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("post_rst_gap", 64'(out_gap), 64'd0);
    chk("post_rst_pc", 64'(out_pc), 64'h600);
    step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
